// File: rtl/fc_bus_arb_pkg.sv
// Shared types and defaults for the fc_bus_arb bus arbiter.
package fc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_ACK     = 3'd2,
    ST_REL     = 3'd3,
    ST_REFRESH = 3'd4
  } state_t;

  localparam int NCH_DEF        = 3;
  localparam int WAIT_W_DEF     = 4;
  localparam int REF_PERIOD_DEF = 128;
  localparam int REF_LEN_DEF    = 4;

  // Wide enough for REF_LEN - 1 over the legal REF_LEN range.
  localparam int REF_LEN_W = 4;

endpackage

// File: rtl/fc_bus_arb_if.sv
// Bus-master request/grant bundle; the arbiter connects through the slave modport.
interface fc_bus_arb_if import fc_pkg::*; #(
  parameter int NCH    = NCH_DEF,
  parameter int WAIT_W = WAIT_W_DEF
);
  localparam int CW = $clog2(NCH);

  logic [NCH-1:0]    req;
  logic              rr_mode;
  logic [WAIT_W-1:0] wait_cnt;
  logic [NCH-1:0]    gnt;
  logic [NCH-1:0]    ack;
  logic [CW-1:0]     ch;
  logic              busy;
  logic              ref_o;

  modport master (
    output req, rr_mode, wait_cnt,
    input  gnt, ack, ch, busy, ref_o
  );

  modport slave (
    input  req, rr_mode, wait_cnt,
    output gnt, ack, ch, busy, ref_o
  );

endinterface

// File: rtl/fc_bus_arb_rr_pick.sv
// Combinational winner selection: fixed priority (lowest index) or round-robin from rr_ptr.
module fc_rr_pick #(
  parameter int NCH = 3
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] rr_ptr,
  input  logic                   rr_mode,
  output logic [$clog2(NCH)-1:0] winner,
  output logic                   valid
);
  localparam int CW  = $clog2(NCH);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] NCH_V = CW1'(NCH);

  logic [CW-1:0]  shift_s;
  logic [NCH-1:0] src_s;
  logic [CW-1:0]  pos_s;
  logic [CW:0]    sum_s;
  logic [CW:0]    diff_s;

  // Rotate so the search start sits at bit 0, find the lowest set bit, then un-rotate.
  always_comb begin
    shift_s = rr_mode ? rr_ptr : '0;
    src_s   = NCH'({req, req} >> shift_s);
    pos_s   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      pos_s = src_s[i] ? CW'(i) : pos_s;
    end
    sum_s  = {1'b0, pos_s} + {1'b0, shift_s};
    diff_s = sum_s - NCH_V;
    winner = (sum_s >= NCH_V) ? diff_s[CW-1:0] : sum_s[CW-1:0];
    valid  = |req;
  end

endmodule

// File: rtl/fc_bus_arb.sv
// Bus arbiter with wait states, DTACK-style ack and optional DRAM refresh slots.
// Refresh logic is present only when FC_BUS_ARB_REFRESH_EN is defined.
module fc_bus_arb import fc_pkg::*; #(
  parameter int NCH        = NCH_DEF,
  parameter int WAIT_W     = WAIT_W_DEF,
  parameter int REF_PERIOD = REF_PERIOD_DEF,
  parameter int REF_LEN    = REF_LEN_DEF
) (
  input  logic         MCLK,
  input  logic         SRES,
  fc_bus_arb_if.slave  bus
);
  localparam int CW = $clog2(NCH);
  localparam logic [NCH-1:0] GNT_ONE = NCH'(1);
  localparam logic [CW-1:0]  LAST_CH = CW'(NCH - 1);

  if (NCH < 2 || NCH > 8 || REF_PERIOD < 8 || REF_PERIOD > 4096 ||
      REF_LEN < 1 || REF_LEN > 15) begin : g_param_check
    $error("fc_bus_arb: parameter out of legal range");
  end

  state_t            state_r;
  logic [NCH-1:0]    gnt_r;
  logic [NCH-1:0]    ack_r;
  logic [CW-1:0]     ch_r;
  logic [CW-1:0]     rr_ptr_r;
  logic              busy_r;
  logic [WAIT_W-1:0] wait_r;
  logic [CW-1:0]     pick_s;
  logic              pick_valid_s;
  logic              ref_start_s;
  logic              owner_req_s;

  assign owner_req_s = bus.req[ch_r];

  fc_rr_pick #(.NCH(NCH)) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_r),
    .rr_mode (bus.rr_mode),
    .winner  (pick_s),
    .valid   (pick_valid_s)
  );

`ifdef FC_BUS_ARB_REFRESH_EN
  localparam int RCW = $clog2(REF_PERIOD);
  localparam logic [RCW-1:0] REF_LAST = RCW'(REF_PERIOD - 1);

  logic [RCW-1:0]       ref_cnt_r;
  logic                 ref_pend_r;
  logic                 ref_wrap_s;
  logic [REF_LEN_W-1:0] ref_len_r;
  logic                 ref_o_r;

  assign ref_wrap_s  = (ref_cnt_r == REF_LAST);
  assign ref_start_s = (state_r == ST_IDLE) && ref_pend_r;

  // Free-running refresh timer; a wrap while a refresh is already pending is dropped
  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      ref_cnt_r  <= '0;
      ref_pend_r <= 1'b0;
    end else begin
      ref_cnt_r <= ref_wrap_s ? '0 : ref_cnt_r + RCW'(1);
      if (ref_start_s) begin
        ref_pend_r <= 1'b0;
      end else if (ref_wrap_s) begin
        ref_pend_r <= 1'b1;
      end else begin
        ref_pend_r <= ref_pend_r;
      end
    end
  end

  assign bus.ref_o = ref_o_r;
`else
  assign ref_start_s = 1'b0;
  assign bus.ref_o   = 1'b0;
`endif

  // Arbitration FSM; every bus output is a flop
  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      state_r  <= ST_IDLE;
      gnt_r    <= '0;
      ack_r    <= '0;
      ch_r     <= '0;
      rr_ptr_r <= '0;
      busy_r   <= 1'b0;
      wait_r   <= '0;
`ifdef FC_BUS_ARB_REFRESH_EN
      ref_o_r   <= 1'b0;
      ref_len_r <= '0;
`endif
    end else begin
      ack_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (ref_start_s) begin
`ifdef FC_BUS_ARB_REFRESH_EN
            state_r   <= ST_REFRESH;
            busy_r    <= 1'b1;
            ref_o_r   <= 1'b1;
            ref_len_r <= REF_LEN_W'(REF_LEN - 1);
`else
            state_r <= ST_IDLE;
`endif
          end else if (pick_valid_s) begin
            state_r  <= ST_GRANT;
            ch_r     <= pick_s;
            gnt_r    <= GNT_ONE << pick_s;
            wait_r   <= bus.wait_cnt;
            rr_ptr_r <= (pick_s == LAST_CH) ? '0 : pick_s + CW'(1);
            busy_r   <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // Owner withdrawing before its ack aborts the cycle without an ack.
          if (!owner_req_s) begin
            state_r <= ST_IDLE;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
          end else if (wait_r == '0) begin
            state_r <= ST_ACK;
            ack_r   <= gnt_r;
          end else begin
            wait_r <= wait_r - WAIT_W'(1);
          end
        end
        ST_ACK: begin
          state_r <= ST_REL;
        end
        ST_REL: begin
          if (!owner_req_s) begin
            state_r <= ST_IDLE;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_REL;
          end
        end
`ifdef FC_BUS_ARB_REFRESH_EN
        ST_REFRESH: begin
          if (ref_len_r == '0) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            ref_o_r <= 1'b0;
          end else begin
            ref_len_r <= ref_len_r - REF_LEN_W'(1);
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          gnt_r   <= '0;
          busy_r  <= 1'b0;
`ifdef FC_BUS_ARB_REFRESH_EN
          ref_o_r <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.ack  = ack_r;
  assign bus.ch   = ch_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_fc_bus_arb.sv
// Self-checking bench for fc_bus_arb: directed scenarios plus random traffic against a transaction-level model.
module tb_fc_bus_arb;
  localparam int NCH        = 3;
  localparam int WAIT_W     = 4;
  localparam int REF_PERIOD = 16;
  localparam int REF_LEN    = 4;
`ifdef FC_BUS_ARB_REFRESH_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif

  logic MCLK = 1'b0;
  logic SRES;
  always #5 MCLK = ~MCLK;

  fc_bus_arb_if #(.NCH(NCH), .WAIT_W(WAIT_W)) bus ();

  fc_bus_arb #(.NCH(NCH), .WAIT_W(WAIT_W), .REF_PERIOD(REF_PERIOD), .REF_LEN(REF_LEN)) dut (
    .MCLK (MCLK),
    .SRES (SRES),
    .bus  (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Transaction-level model: who owns the bus, how long until ack, refresh slot time left.
  int m_owner, m_ch, m_left, m_ptr, m_timer, m_ref_left;
  bit m_ack, m_acked, m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bit_at(input logic [NCH-1:0] v, input int i);
    logic [NCH-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic int model_pick(input logic [NCH-1:0] r, input bit rr);
    int base;
    base = rr ? m_ptr : 0;
    for (int k = 0; k < NCH; k++) begin
      if (bit_at(r, (base + k) % NCH)) return (base + k) % NCH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ch = 0; m_left = 0; m_ptr = 0; m_timer = 0; m_ref_left = 0;
    m_ack = 1'b0; m_acked = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_step();
    bit wrap, start;
    int w;
    if (SRES !== 1'b1) begin
      model_reset();
      return;
    end
    wrap    = REF_EN && (m_timer == REF_PERIOD - 1);
    m_timer = (m_timer + 1) % REF_PERIOD;
    start   = 1'b0;
    if (m_ack) begin
      m_ack = 1'b0;
    end else if (m_ref_left > 0) begin
      m_ref_left--;
    end else if (m_owner >= 0) begin
      if (!bit_at(bus.req, m_owner)) m_owner = -1;
      else if (!m_acked) begin
        if (m_left == 0) begin m_ack = 1'b1; m_acked = 1'b1; end
        else m_left--;
      end
    end else if (m_pend) begin
      m_ref_left = REF_LEN; m_pend = 1'b0; start = 1'b1;
    end else begin
      w = model_pick(bus.req, bus.rr_mode);
      if (w >= 0) begin
        m_owner = w; m_ch = w; m_left = int'(bus.wait_cnt); m_acked = 1'b0; m_ptr = (w + 1) % NCH;
      end
    end
    if (wrap && !start) m_pend = 1'b1;
  endtask

  task automatic compare_all();
    logic [NCH-1:0] one_v, eg, ea;
    bit eb;
    one_v = NCH'(1);
    eg = (m_owner >= 0) ? (one_v << m_owner) : '0;
    ea = m_ack ? eg : '0;
    eb = (m_owner >= 0) || (m_ref_left > 0);
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("ack", 32'(bus.ack), 32'(ea));
    chk("busy", 32'(bus.busy), 32'(eb));
    chk("ref_o", 32'(bus.ref_o), 32'(m_ref_left > 0));
    if (eb) chk("ch", 32'(bus.ch), 32'(m_ch));
    chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'h1);
    chk("ack_in_gnt", 32'((bus.ack & ~bus.gnt) == '0), 32'h1);
  endtask

  task automatic tick();
    @(posedge MCLK);
    model_step();
    @(negedge MCLK);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge MCLK);
    SRES = 1'b0;
    bus.req = '0;
    tick();
    SRES = 1'b1;
  endtask

  task automatic wait_ack(input int bound);
    int i;
    i = 0;
    while (bus.ack == '0 && i < bound) begin
      tick();
      i++;
    end
    chk("ack_seen", 32'(bus.ack != '0), 32'h1);
  endtask

  initial begin
    int cnt;
    logic [NCH-1:0] one_v;
    one_v = NCH'(1);
    SRES = 1'b0;
    bus.req = '0; bus.rr_mode = 1'b0; bus.wait_cnt = '0;
    model_reset();
    repeat (2) @(negedge MCLK);
    compare_all();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_ch", 32'(bus.ch), 32'h0);
    SRES = 1'b1;

    // Fixed priority, zero wait states
    bus.rr_mode = 1'b0; bus.wait_cnt = '0; bus.req = 3'b110;
    tick(); chk("fix_gnt_c1", 32'(bus.gnt), 32'h2); chk("fix_ack_c1", 32'(bus.ack), 32'h0);
    tick(); chk("fix_ack_c2", 32'(bus.ack), 32'h2);
    tick(); chk("fix_ack_c3", 32'(bus.ack), 32'h0); chk("fix_gnt_c3", 32'(bus.gnt), 32'h2);
    bus.req = 3'b000;
    tick(); chk("fix_gnt_drop", 32'(bus.gnt), 32'h0);

    // Round-robin rotation with all masters requesting
    do_reset();
    bus.rr_mode = 1'b1; bus.wait_cnt = 4'd1; bus.req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      wait_ack(40);
      chk("rr_order", 32'(bus.ch), 32'(n % 3));
      bus.req = bus.req & ~(one_v << (n % 3));
      tick();
      tick();
      bus.req = 3'b111;
    end
    bus.req = '0;
    repeat (3) tick();

    // Abort during wait states
    do_reset();
    bus.rr_mode = 1'b0; bus.wait_cnt = 4'd5; bus.req = 3'b001;
    tick(); chk("abort_gnt", 32'(bus.gnt), 32'h1);
    repeat (3) tick();
    bus.req = 3'b000;
    tick(); chk("abort_gnt_fall", 32'(bus.gnt), 32'h0); chk("abort_busy", 32'(bus.busy), 32'h0);
    repeat (6) begin
      tick(); chk("abort_no_ack", 32'(bus.ack), 32'h0);
    end

    // Refresh cadence while idle, then a transfer spanning a timer wrap
    do_reset();
    bus.req = '0; cnt = 0;
    repeat (40) begin
      tick();
      cnt = cnt + 32'(bus.ref_o);
    end
    chk("ref_cycles", 32'(cnt), REF_EN ? 32'd8 : 32'd0);
    bus.rr_mode = 1'b0; bus.wait_cnt = 4'd7; bus.req = 3'b011;
    tick(); chk("wrap_gnt", 32'(bus.gnt), 32'h1);
    wait_ack(20);
    bus.req = 3'b010;
    tick();
    tick();
    tick();
    chk("wrap_ref_first", 32'(bus.ref_o), 32'(REF_EN));
    chk("wrap_gnt_after", 32'(bus.gnt), REF_EN ? 32'h0 : 32'h2);
    bus.req = '0;
    repeat (8) tick();

    // Asynchronous reset during ACK
    do_reset();
    bus.rr_mode = 1'b1; bus.wait_cnt = 4'd2; bus.req = 3'b001;
    wait_ack(20);
    SRES = 1'b0;
    #1;
    model_reset();
    chk("arst_gnt", 32'(bus.gnt), 32'h0);
    chk("arst_ack", 32'(bus.ack), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_ch", 32'(bus.ch), 32'h0);
    chk("arst_ref", 32'(bus.ref_o), 32'h0);
    tick();
    SRES = 1'b1;
    bus.req = 3'b011;
    tick(); chk("arst_regnt", 32'(bus.gnt), 32'h1); chk("arst_rech", 32'(bus.ch), 32'h0);
    bus.req = '0;
    repeat (3) tick();

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = bus.req ^ (one_v << $urandom_range(0, NCH - 1));
      if ($urandom_range(0, 7) == 0) bus.rr_mode = ~bus.rr_mode;
      bus.wait_cnt = ($urandom_range(0, 7) == 0) ? WAIT_W'($urandom_range(0, 15)) : WAIT_W'($urandom_range(0, 3));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
